// File: rtl/gauss_sample_buffer_if.sv
// Sample-path bundle between the Box-Muller generator, the sample buffer and the
// downstream consumer: pair strobe in, scaled sample stream out.
interface gauss_sample_buffer_if;
  logic        in_valid;
  logic [15:0] in_grv1;
  logic [15:0] in_grv2;
  logic        gen_enable;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] unused_pad;
  logic        out_last;

  modport master (
    output in_valid, in_grv1, in_grv2, out_ready,
    input  gen_enable, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_grv1, in_grv2, out_ready,
    output gen_enable, out_valid, out_data, out_last
  );
endinterface

// File: rtl/gauss_sample_buffer.sv
// Pair FIFO behind the Box-Muller generator: serializes (grv1, grv2) into one stream
// and applies a saturating affine gain/offset to form cell threshold-voltage noise.
module gauss_sample_buffer #(
  parameter int DEPTH      = 8,
  parameter int SCALE_FRAC = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  gauss_sample_buffer_if.slave       bus,
  input  logic                       flush,
  input  logic [15:0]                scale_i,
  input  logic [15:0]                offset_i,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       sat_flag,
  output logic [15:0]                drop_count
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int PW     = DATA_W + COEF_W + 1;
  localparam int RW     = PW + 1;

  // Product of signed sample and unsigned gain, floored, plus the offset, one guard bit wide.
  function automatic logic signed [RW-1:0] affine(input logic signed [DATA_W-1:0] x,
                                                  input logic [COEF_W-1:0]        s,
                                                  input logic signed [DATA_W-1:0] o);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    p = $signed({{(COEF_W+1){x[DATA_W-1]}}, x}) * $signed({{(DATA_W+1){1'b0}}, s});
    q = p >>> SCALE_FRAC;
    return $signed({q[PW-1], q} + {{(COEF_W+2){o[DATA_W-1]}}, o});
  endfunction

  function automatic logic sat_hit(input logic signed [RW-1:0] r);
    return !((&r[RW-1:DATA_W-1]) || (~|r[RW-1:DATA_W-1]));
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_clip(input logic signed [RW-1:0] r);
    if (sat_hit(r)) return r[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return r[DATA_W-1:0];
  endfunction

  logic [2*DATA_W-1:0]        mem_q [DEPTH];
  logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]              level_q, level_d;
  logic                       sel_q;
  logic                       vld_p0_q, last_p0_q;
  logic signed [DATA_W-1:0]   x_p0_q;
  logic                       vld_p1_q, last_p1_q;
  logic signed [DATA_W-1:0]   data_p1_q;
  logic                       ovf_q, sat_q;
  logic [15:0]                drop_q;

  logic                       full, empty, adv_p1, load_p0, pop, wr, drop;
  logic [2*DATA_W-1:0]        head;
  logic signed [DATA_W-1:0]   x_sel;
  logic signed [RW-1:0]       r_p0;
  logic signed [DATA_W-1:0]   y_p0;
  logic                       s_p0;

  // Full is judged on the pre-edge level, so a same-edge pop never rescues a write.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign adv_p1  = !vld_p1_q || bus.out_ready;
  assign load_p0 = adv_p1 && !empty;
  assign pop     = load_p0 && sel_q;
  assign wr      = bus.in_valid && !flush && !full;
  assign drop    = bus.in_valid && !flush && full;
  assign level_d = level_q + LW'(wr) - LW'(pop);

  assign head  = mem_q[rd_ptr_q];
  assign x_sel = sel_q ? $signed(head[DATA_W-1:0]) : $signed(head[2*DATA_W-1:DATA_W]);

  assign r_p0 = affine(x_p0_q, scale_i, $signed(offset_i));
  assign y_p0 = sat_clip(r_p0);
  assign s_p0 = sat_hit(r_p0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sel_q     <= 1'b0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      last_p1_q <= 1'b0;
      ovf_q     <= 1'b0;
      sat_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        sel_q    <= 1'b0;
        vld_p0_q <= 1'b0;
        vld_p1_q <= 1'b0;
      end else begin
        if (wr)      wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        level_q <= level_d;
        if (load_p0) sel_q    <= ~sel_q;
        // Stage A -> stage B boundary
        if (adv_p1) begin
          vld_p0_q <= load_p0;
          vld_p1_q <= vld_p0_q;
          if (vld_p0_q) begin
            data_p1_q <= y_p0;
            last_p1_q <= last_p0_q;
            if (s_p0) sat_q <= 1'b1;
          end
        end
      end
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  // FIFO -> stage A boundary
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {bus.in_grv1, bus.in_grv2};
    if (load_p0) begin
      x_p0_q    <= x_sel;
      last_p0_q <= sel_q;
    end
  end

  assign bus.gen_enable = (level_q <= LW'(DEPTH - 2));
  assign bus.out_valid  = vld_p1_q;
  assign bus.out_data   = data_p1_q;
  assign bus.out_last   = last_p1_q;
  assign level          = level_q;
  assign overflow       = ovf_q;
  assign sat_flag       = sat_q;
  assign drop_count     = drop_q;

endmodule

// File: doc/gauss_sample_buffer.md
Name: gauss_sample_buffer

Overview:
- Sits directly downstream of the Box-Muller generator top.
- Captures each (grv1, grv2) pair on outputvalid into a pair FIFO.
- Serializes each pair into a single sample stream, grv1 first then grv2.
- Applies an affine transform y = offset + scale*x with saturation, producing the threshold-voltage noise samples for the NAND flash cell model. Output uses a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO capacity in sample pairs; power of two, at least 4.
- SCALE_FRAC, 12, fractional bits of scale_i (scale_i is unsigned Q4.12 at the default).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  pair strobe; connects to generator outputvalid.
- in_grv1  input  16  signed sample 1, two's complement.
- in_grv2  input  16  signed sample 2, two's complement.
- gen_enable  output  1  enable back to generator; high while FIFO level <= DEPTH-2.
- flush  input  1  synchronous clear of FIFO and output stage.
- scale_i  input  16  unsigned gain.
- offset_i  input  16  signed offset.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the sample.
- out_data  output  16  signed scaled sample.
- out_last  output  1  high when out_data is the second (grv2) sample of a pair.
- level  output  log2(DEPTH)+1  pairs held in FIFO, excluding the pair at the output stage.
- overflow  output  1  sticky; a pair was dropped.
- sat_flag  output  1  sticky; at least one output saturated.
- drop_count  output  16  pairs dropped; saturates at 0xFFFF.

Behaviour:
- Reset (async, active-high) clears:
  - out_valid=0, out_data=0, out_last=0, level=0, overflow=0, sat_flag=0, drop_count=0.
  - FIFO read/write pointers and the half-select bit (select=0).
  - gen_enable=1.
- Write side:
  - in_valid with level<DEPTH writes {in_grv1,in_grv2} on that edge.
  - in_valid with level==DEPTH drops the pair: FIFO is unchanged, overflow is set, drop_count increments (saturating).
  - in_valid is a 1-cycle strobe; there is no upstream back-pressure beyond gen_enable.
- Stage pipeline:
  - Stage A (registered): on an edge where out_valid==0 or (out_valid && out_ready), stage A loads from the FIFO head if the FIFO is non-empty.
  - Stage A loads the grv1 or grv2 field according to the select bit, and registers the signed x and the select value.
  - Stage B (registered, drives the outputs) computes out_data from stage A.
  - Write-to-out_valid latency, FIFO and stages empty: out_valid rises on the 2nd rising edge after the write edge.
  - Sustained throughput is 1 sample per cycle with out_ready held high.
- Serialization:
  - select toggles on each stage-A load.
  - The FIFO pops its head only on the stage-A load of the grv2 half (select=1).
  - out_last=1 for grv2 samples.
- Handshake:
  - A transfer occurs on an edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last are held stable and the pipeline stalls. Stage A and stage B are both full and do not advance.
  - out_valid never deasserts without a transfer, except on flush or reset.
- Arithmetic:
  - p = signed(x) * unsigned(scale_i), 33-bit signed.
  - q = p >>> SCALE_FRAC (arithmetic shift, floor).
  - r = q + sign-extended offset_i.
  - r > 32767 gives 32767, r < -32768 gives -32768; either case sets sat_flag.
  - scale_i and offset_i are sampled at the stage B compute edge. They must be changed only when out_valid==0, otherwise the result is undefined.
- Simultaneous events:
  - Write and pop on the same edge: level is unchanged. Writing when level==DEPTH and a pop occurs on that edge is still a drop; full is evaluated before the edge.
- flush:
  - Empties the FIFO and both stages, and sets select=0, out_valid=0 and level=0 on the next edge.
  - overflow, sat_flag and drop_count are retained.
  - An in_valid on the same edge as flush is discarded and not counted.
- Reset mid-operation: all in-flight samples are lost; outputs go to reset values immediately (asynchronously).

Test Plan:
- Unity scaling: scale_i=0x1000, offset_i=0, out_ready=1, one pair (0x0400, 0xFC00).
  - out_valid rises on the 2nd edge after the write edge.
  - Outputs are 0x0400 (out_last=0) then 0xFC00 (out_last=1) on consecutive cycles; level returns to 0.
- Gain and offset: scale_i=0x2000, offset_i=0x0100, pair (0x0400, 0xFF00).
  - Outputs are 0x0900 then 0xFF00 (-512+256=-256).
- Saturation: scale_i=0xF000, pair (0x4000, 0xC000).
  - Outputs are 0x7FFF then 0x8000; sat_flag=1 and stays set after a further in-range pair.
- Overflow and enable: DEPTH=8, out_ready=0, 10 pairs written on consecutive cycles.
  - gen_enable drops once level reaches 7.
  - level saturates at 8 (with one pair held in the stages); overflow=1 and drop_count equals the number of pairs dropped (1).
  - Releasing out_ready drains pairs in write order with no gaps.
- Back-pressure: toggle out_ready pseudo-randomly during a 20-pair stream.
  - out_data is stable whenever valid && !ready.
  - The sample sequence equals a reference model (g1_0, g2_0, g1_1, ...) with no loss or duplication.
- Flush and reset mid-stream: flush with 3 pairs queued.
  - Next cycle: out_valid=0, level=0, select=0; drop_count is retained.
  - Assert reset with data queued: all outputs are zero and gen_enable=1 immediately (asynchronously).
